// File: rtl/game_sequencer.sv
// Run-control FSM for the 8x8 LED game: paces scroll/fall enables, tracks level and speed,
// and sequences IDLE -> PLAY <-> PAUSE -> OVER -> IDLE.
module game_sequencer #(
  parameter int unsigned CW          = 8,
  parameter int unsigned SCROLL_INIT = 64,
  parameter int unsigned SCROLL_MIN  = 16,
  parameter int unsigned SCROLL_STEP = 8,
  parameter int unsigned LEVEL_PTS   = 5,
  parameter int unsigned FALL_DIV    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       crash,
  input  logic       pass,
  output logic       scroll_en,
  output logic       fall_en,
  output logic       clear,
  output logic       game_over,
  output logic [1:0] state,
  output logic [2:0] level
);

  // Period needs one extra bit so a full 2^CW period is representable.
  localparam int unsigned PW  = CW + 1;
  localparam int unsigned FW  = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam int unsigned PCW = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;

  localparam logic [PW-1:0]  PERIOD_INIT = PW'(SCROLL_INIT);
  localparam logic [PW-1:0]  PERIOD_MIN  = PW'(SCROLL_MIN);
  localparam logic [PW-1:0]  PERIOD_STEP = PW'(SCROLL_STEP);
  localparam logic [PW:0]    FLOOR_THR   = (PW+1)'(SCROLL_MIN + SCROLL_STEP);
  localparam logic [FW-1:0]  FDIV_LAST   = FW'(FALL_DIV - 1);
  localparam logic [PCW-1:0] PTS_LAST    = PCW'(LEVEL_PTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  period_q, period_d;
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [2:0]     level_q, level_d;

  logic           scroll_hit_s;
  logic           fall_hit_s;
  logic [PW-1:0]  period_m1_s;

  // Enable decodes use registered state only; >= forces a prompt scroll after a speed-up.
  always_comb begin
    period_m1_s  = period_q - PW'(1);
    scroll_hit_s = (state_q == S_PLAY) && ({1'b0, cnt_q} >= period_m1_s);
    fall_hit_s   = scroll_hit_s && (fcnt_q == FDIV_LAST);
  end

  assign scroll_en = scroll_hit_s;
  assign fall_en   = fall_hit_s;
  assign clear     = (state_q == S_IDLE);
  assign game_over = (state_q == S_OVER);
  assign state     = state_q;
  assign level     = level_q;

  // Next-state, counter and speed-level logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    fcnt_d   = fcnt_q;
    pcnt_d   = pcnt_q;
    level_d  = level_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PLAY;
          cnt_d   = {CW{1'b0}};
          fcnt_d  = {FW{1'b0}};
          pcnt_d  = {PCW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        if (scroll_hit_s) begin
          cnt_d  = {CW{1'b0}};
          fcnt_d = (fcnt_q == FDIV_LAST) ? {FW{1'b0}} : fcnt_q + FW'(1);
        end else begin
          cnt_d  = cnt_q + CW'(1);
          fcnt_d = fcnt_q;
        end
        if (crash) begin
          state_d = S_OVER;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (pass) begin
          state_d = S_PLAY;
          if (pcnt_q == PTS_LAST) begin
            pcnt_d   = {PCW{1'b0}};
            level_d  = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
            period_d = ({1'b0, period_q} >= FLOOR_THR) ? period_q - PERIOD_STEP : PERIOD_MIN;
          end else begin
            pcnt_d = pcnt_q + PCW'(1);
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_PAUSE: begin
        if (!pause) begin
          state_d = S_PLAY;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_OVER: begin
        if (start) begin
          state_d  = S_IDLE;
          period_d = PERIOD_INIT;
          level_d  = 3'd0;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      period_q <= PERIOD_INIT;
      fcnt_q   <= {FW{1'b0}};
      pcnt_q   <= {PCW{1'b0}};
      level_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      fcnt_q   <= fcnt_d;
      pcnt_q   <= pcnt_d;
      level_q  <= level_d;
    end
  end

endmodule
